bk_adder_pipe: RTL and testbench

BK_ADDER_PIPE -- requirements
Module: bk_adder_pipe

---
 rtl/bk_adder_pipe.sv | 254 +++++++++++++++++++++++++
 tb/tb_bk_adder_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: pipelined Brent-Kung prefix adder with a valid/ready stream
// interface. Computes {c_out, s} = a + (sub ? ~b : b) + c_in.
//
// Parameters
//   WIDTH  : operand width, power of two, 8..256
//   STAGES : registers from operand capture to result, 1..log2(WIDTH)+1
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : operands valid
//   in_ready  : operands accepted this cycle (= pipeline advance)
//   a, b      : operands
//   c_in      : carry-in
//   sub       : 1 selects a + ~b + c_in
//   out_valid : result valid
//   out_ready : consumer accepts result
//   s         : sum
//   c_out     : carry-out of bit WIDTH-1
//   ovf       : signed overflow (only when BK_ADDER_OVF_EN is defined)
//
// Optional feature macro: BK_ADDER_OVF_EN adds the ovf output.
//
// Register placement: with STAGES >= 2 the first register captures operands
// and the last one holds s/c_out; the remaining STAGES-2 registers are cut
// into the 2*log2(WIDTH)-1 prefix levels at evenly spaced points. With
// STAGES == 1 the whole adder is combinational in front of the output register.

`default_nettype none

module bk_adder_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef BK_ADDER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);

  localparam int LOG2W = $clog2(WIDTH);
  // Up-sweep LOG2W levels plus down-sweep LOG2W-1 levels.
  localparam int NLEV  = 2 * LOG2W - 1;
  localparam int NCUT  = int'(STAGES) - 2;

  // True when a pipeline register follows prefix level lvl.
  function automatic bit is_cut(input int lvl);
    bit hit;
    hit = 1'b0;
    for (int j = 1; j <= NCUT; j++) begin
      if (((j * NLEV) + ((int'(STAGES) - 1) / 2)) / (int'(STAGES) - 1) == lvl) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_opc;
  logic [WIDTH-1:0] w_beff;
  logic             w_last_vld;
  logic [STAGES-1:0] r_vld;

  // Whole pipeline moves together whenever the output slot is free or drains.
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign w_beff    = sub ? ~b : b;

  // Valid shift register, one bit per stage.
  if (STAGES > 1) begin : g_vld_shift
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= '0;
      end else if (w_adv) begin
        r_vld <= {r_vld[STAGES-2:0], in_valid};
      end
    end
    assign w_last_vld = r_vld[STAGES-2];
  end else begin : g_vld_one
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= '0;
      end else if (w_adv) begin
        r_vld <= in_valid;
      end
    end
    assign w_last_vld = in_valid;
  end

  // Operand capture; loads only on an accepted transfer so idle inputs are ignored.
  if (STAGES > 1) begin : g_cap
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ci;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_a  <= '0;
        r_b  <= '0;
        r_ci <= 1'b0;
      end else if (w_adv && in_valid) begin
        r_a  <= a;
        r_b  <= w_beff;
        r_ci <= c_in;
      end
    end

    assign w_opa = r_a;
    assign w_opb = r_b;
    assign w_opc = r_ci;
  end else begin : g_nocap
    assign w_opa = a;
    assign w_opb = w_beff;
    assign w_opc = c_in;
  end

  // Level 0 forms per-bit (g, p); levels 1..NLEV form the Brent-Kung prefix.
  // Each level carries g/p plus the original propagate x and c_in for the sum.
  for (genvar l = 0; l <= NLEV; l++) begin : g_lvl
    logic [WIDTH-1:0] w_g_d;
    logic [WIDTH-1:0] w_p_d;
    logic [WIDTH-1:0] w_x_d;
    logic             w_ci_d;
    logic [WIDTH-1:0] w_g_q;
    logic [WIDTH-1:0] w_p_q;
    logic [WIDTH-1:0] w_x_q;
    logic             w_ci_q;

    if (l == 0) begin : g_gp
      // c_in is folded into bit 0's generate so G[i] is the carry into bit i+1.
      assign w_g_d[WIDTH-1:1] = w_opa[WIDTH-1:1] & w_opb[WIDTH-1:1];
      assign w_g_d[0]         = (w_opa[0] & w_opb[0]) | ((w_opa[0] ^ w_opb[0]) & w_opc);
      assign w_p_d            = w_opa ^ w_opb;
      assign w_x_d            = w_opa ^ w_opb;
      assign w_ci_d           = w_opc;
    end else begin : g_pfx
      localparam bit UP   = (l <= LOG2W);
      localparam int K    = UP ? l : (2 * LOG2W - l);
      localparam int SPAN = 1 << K;
      localparam int DIST = SPAN / 2;

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Up-sweep: combine at the top bit of each SPAN block.
        // Down-sweep: fill the midpoints of blocks above the first.
        if ((UP && (((i + 1) % SPAN) == 0)) ||
            (!UP && (((i + 1) % SPAN) == DIST) && (i >= SPAN))) begin : g_op
          assign w_g_d[i] = g_lvl[l-1].w_g_q[i] |
                            (g_lvl[l-1].w_p_q[i] & g_lvl[l-1].w_g_q[i-DIST]);
          assign w_p_d[i] = g_lvl[l-1].w_p_q[i] & g_lvl[l-1].w_p_q[i-DIST];
        end else begin : g_pass
          assign w_g_d[i] = g_lvl[l-1].w_g_q[i];
          assign w_p_d[i] = g_lvl[l-1].w_p_q[i];
        end
      end

      assign w_x_d  = g_lvl[l-1].w_x_q;
      assign w_ci_d = g_lvl[l-1].w_ci_q;
    end

    if (is_cut(l)) begin : g_cut
      logic [WIDTH-1:0] r_g;
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_x;
      logic             r_ci;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_g  <= '0;
          r_p  <= '0;
          r_x  <= '0;
          r_ci <= 1'b0;
        end else if (w_adv) begin
          r_g  <= w_g_d;
          r_p  <= w_p_d;
          r_x  <= w_x_d;
          r_ci <= w_ci_d;
        end
      end

      assign w_g_q  = r_g;
      assign w_p_q  = r_p;
      assign w_x_q  = r_x;
      assign w_ci_q = r_ci;
    end else begin : g_thru
      assign w_g_q  = w_g_d;
      assign w_p_q  = w_p_d;
      assign w_x_q  = w_x_d;
      assign w_ci_q = w_ci_d;
    end
  end

  // Group propagate of the final level has no consumer.
  logic w_unused_p;
  assign w_unused_p = ^g_lvl[NLEV].w_p_q;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;

  assign w_sum  = g_lvl[NLEV].w_x_q ^ {g_lvl[NLEV].w_g_q[WIDTH-2:0], g_lvl[NLEV].w_ci_q};
  assign w_cout = g_lvl[NLEV].w_g_q[WIDTH-1];

  // Output register; holds the last result through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s     <= '0;
      r_c_out <= 1'b0;
    end else if (w_adv && w_last_vld) begin
      r_s     <= w_sum;
      r_c_out <= w_cout;
    end
  end

  assign s     = r_s;
  assign c_out = r_c_out;

`ifdef BK_ADDER_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign w_ovf = g_lvl[NLEV].w_g_q[WIDTH-1] ^ g_lvl[NLEV].w_g_q[WIDTH-2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv && w_last_vld) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bk_adder_pipe.sv
// Directed and streaming bench for bk_adder_pipe (WIDTH=64, STAGES=2).
module tb_bk_adder_pipe;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned STAGES = 2;
  localparam int unsigned W1     = WIDTH + 1;
  localparam int unsigned NSTREAM = 100;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
`ifdef BK_ADDER_OVF_EN
  logic             ovf;
`endif

  int checks;
  int failures;

  bk_adder_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef BK_ADDER_OVF_EN
    .c_out     (c_out),
    .ovf       (ovf)
`else
    .c_out     (c_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W1-1:0] obs, input logic [W1-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation through an empty pipeline with out_ready high.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tci, input logic tsub, input logic [WIDTH-1:0] es, input logic ec);
    a = ta; b = tb; c_in = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, W1'(in_ready), W1'(1'b1));
    tick();
    in_valid = 1'b0; a = ~ta; b = ~tb; c_in = ~tci; sub = ~tsub;
    for (int k = 1; k < int'(STAGES); k++) begin
      chk({tag, "_early_valid"}, W1'(out_valid), W1'(1'b0));
      tick();
    end
    chk({tag, "_valid"}, W1'(out_valid), W1'(1'b1));
    chk({tag, "_sum"}, {c_out, s}, {ec, es});
`ifdef BK_ADDER_OVF_EN
    begin
      logic [WIDTH-1:0] beff;
      beff = tsub ? ~tb : tb;
      chk({tag, "_ovf"}, W1'(ovf), W1'((ta[WIDTH-1] == beff[WIDTH-1]) && (es[WIDTH-1] != ta[WIDTH-1])));
    end
`endif
    tick();
    chk({tag, "_bubble"}, W1'(out_valid), W1'(1'b0));
  endtask

  initial begin
    logic [W1-1:0]    q_exp[$];
    logic [W1-1:0]    exp_v;
    logic [WIDTH-1:0] held_s;
    logic             held_c;
    logic             held_pending;
    int               sent;
    int               got;

    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", W1'(out_valid), W1'(1'b0));
    chk("rst_sum", {c_out, s}, W1'(0));
`ifdef BK_ADDER_OVF_EN
    chk("rst_ovf", W1'(ovf), W1'(1'b0));
`endif
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", W1'(in_ready), W1'(1'b1));

    // Directed vectors
    run_op("v3333", 64'h3333_3333_3333_3333, 64'h3333_3333_3333_3333, 1'b0, 1'b0, 64'h6666_6666_6666_6666, 1'b0);
    run_op("vall1_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
    run_op("vsub5_7", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("vsub7_5", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1);
    run_op("vmaxpos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    run_op("vzero", 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    run_op("vall1_all1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("vminneg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1);
    run_op("vsub0_0", 64'h0, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("vnocarry", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("valt", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 64'h0, 1'b1);

    // Stall: result must hold while out_ready is low
    a = 64'h0000_0001_0000_0000; b = 64'h0000_0000_FFFF_FFFF; c_in = 1'b1; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < int'(STAGES); k++) tick();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", W1'(out_valid), W1'(1'b1));
      chk("stall_sum", {c_out, s}, {1'b0, 64'h0000_0002_0000_0000});
      chk("stall_in_ready", W1'(in_ready), W1'(1'b0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", W1'(in_ready), W1'(1'b1));
    tick();
    chk("stall_drained", W1'(out_valid), W1'(1'b0));

    // Random stream with random back-pressure against a (WIDTH+1)-bit golden sum
    sent = 0; got = 0; held_pending = 1'b0; held_s = '0; held_c = 1'b0;
    for (int cyc = 0; cyc < 4000 && got < int'(NSTREAM); cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < int'(NSTREAM)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_pending) begin
        chk("stream_hold_valid", W1'(out_valid), W1'(1'b1));
        chk("stream_hold_sum", {c_out, s}, {held_c, held_s});
      end
      if (out_valid && out_ready) begin
        chk("stream_nonempty", W1'(q_exp.size() > 0), W1'(1'b1));
        if (q_exp.size() > 0) begin
          exp_v = q_exp.pop_front();
          chk("stream_sum", {c_out, s}, exp_v);
        end
        got++;
      end
      held_pending = out_valid && !out_ready;
      held_s = s; held_c = c_out;
      if (in_valid && in_ready) begin
        q_exp.push_back({1'b0, a} + {1'b0, (sub ? ~b : b)} + W1'(c_in));
        sent++;
      end
      tick();
    end
    chk("stream_count", W1'(got), W1'(NSTREAM));
    chk("stream_leftover", W1'(q_exp.size()), W1'(0));

    // Reset with STAGES operations in flight
    in_valid = 1'b1; out_ready = 1'b0; sub = 1'b0; c_in = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      a = 64'(k + 1); b = 64'(k + 10);
      tick();
    end
    chk("inflight_valid", W1'(out_valid), W1'(1'b1));
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", W1'(out_valid), W1'(1'b0));
    chk("midrst_sum", {c_out, s}, W1'(0));
    chk("midrst_in_ready", W1'(in_ready), W1'(1'b1));
    out_ready = 1'b1;
    for (int k = 0; k < 2 * int'(STAGES) + 2; k++) begin
      tick();
      chk("midrst_no_stale", W1'(out_valid), W1'(1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
